// File: rtl/pixie_dma_sequencer.sv
// CDP1861-style display timing and DMA sequencer: machine-cycle/line/frame counters,
// INT/EFx/DMAO generation and DMA-out capture into frame buffer port A.
// Optional macro PIXIE_DMA_OVERRUN_EN adds a sticky dma_overrun output.
module pixie_dma_sequencer #(
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned CYCLES_PER_LINE = 14,
    parameter int unsigned FIRST_DISP_LINE = 80,
    parameter int unsigned DISP_LINES      = 128,
    parameter int unsigned BYTES_PER_LINE  = 8,
    parameter int unsigned DMA_START_CYCLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic [1:0] SC,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic [7:0] data_in,
    output logic       DMAO,
    output logic       INT,
    output logic       EFx,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_wr_en,
    output logic       frame_start
`ifdef PIXIE_DMA_OVERRUN_EN
    ,
    output logic       dma_overrun
`endif
);

    localparam logic [3:0] C_LAST_CYCLE = 4'(CYCLES_PER_LINE - 1);
    localparam logic [3:0] C_PRE_START  = 4'(DMA_START_CYCLE - 1);
    localparam logic [8:0] L_LAST_LINE  = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] L_FIRST_DISP = 9'(FIRST_DISP_LINE);
    localparam logic [8:0] L_PRE_DISP   = 9'(FIRST_DISP_LINE - 1);
    localparam logic [8:0] L_LAST_DISP  = 9'(FIRST_DISP_LINE + DISP_LINES - 1);
    localparam logic [8:0] L_EFX_TOP    = 9'(FIRST_DISP_LINE - 4);
    localparam logic [8:0] L_EFX_BOT    = 9'(FIRST_DISP_LINE + DISP_LINES - 4);
    localparam logic [8:0] L_INT_FIRST  = 9'(FIRST_DISP_LINE - 2);
    localparam logic [2:0] B_LAST       = 3'(BYTES_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cycle;
    logic [8:0] r_line;
    logic [6:0] r_row;
    logic [2:0] r_byte;
    logic       r_enable;

    logic       w_cycle_last;
    logic       w_line_wrap;
    logic       w_frame_wrap;
    logic [3:0] w_cycle_next;
    logic [8:0] w_line_next;
    logic       w_enable_next;
    logic       w_disp_line;
    logic       w_start;
    logic       w_accept;
    logic       w_efx_next;
    logic       w_int_line_next;

    assign w_cycle_last  = (r_cycle == C_LAST_CYCLE);
    assign w_line_wrap   = clk_enable & w_cycle_last;
    assign w_frame_wrap  = w_line_wrap & (r_line == L_LAST_LINE);
    assign w_cycle_next  = !clk_enable ? r_cycle : (w_cycle_last ? 4'd0 : r_cycle + 4'd1);
    assign w_line_next   = !w_line_wrap ? r_line : (w_frame_wrap ? 9'd0 : r_line + 9'd1);
    assign w_enable_next = disp_off ? 1'b0 : (disp_on ? 1'b1 : r_enable);
    assign w_disp_line   = (r_line >= L_FIRST_DISP) && (r_line <= L_LAST_DISP);
    assign w_start       = clk_enable && (r_cycle == C_PRE_START) && r_enable && w_disp_line;

    // Flags are decoded from the next line value so they line up with the registered counters.
    assign w_efx_next = ((w_line_next >= L_EFX_TOP) && (w_line_next < L_FIRST_DISP)) ||
                        ((w_line_next >= L_EFX_BOT) && (w_line_next <= L_LAST_DISP));
    assign w_int_line_next = (w_line_next >= L_INT_FIRST) && (w_line_next < L_FIRST_DISP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Line wrap beats disp_off, which beats an accept in the same clock.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_line_wrap) begin
                    w_state_next = S_IDLE;
                end else if (disp_off) begin
                    w_state_next = S_IDLE;
                end else if (clk_enable && (SC == 2'b10)) begin
                    w_accept = 1'b1;
                    if (r_byte == B_LAST) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (w_line_wrap) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle     <= 4'd0;
            r_line      <= 9'd0;
            r_row       <= 7'd0;
            r_byte      <= 3'd0;
            r_enable    <= 1'b0;
            DMAO        <= 1'b0;
            INT         <= 1'b0;
            EFx         <= 1'b0;
            mem_addr    <= 10'd0;
            mem_data    <= 8'd0;
            mem_wr_en   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_cycle     <= w_cycle_next;
            r_line      <= w_line_next;
            r_enable    <= w_enable_next;
            frame_start <= w_frame_wrap;
            EFx         <= w_efx_next;
            INT         <= w_enable_next & w_int_line_next;
            DMAO        <= (w_state_next == S_REQ);
            mem_wr_en   <= w_accept;
            if (w_accept) begin
                mem_addr <= {r_row, r_byte};
                mem_data <= data_in;
                r_byte   <= r_byte + 3'd1;
            end else if ((r_state == S_REQ) && (w_state_next == S_IDLE)) begin
                r_byte <= 3'd0;
            end
            // Row advances at the end of every display line, even a starved or aborted one.
            if (w_line_wrap) begin
                if (r_line == L_PRE_DISP) begin
                    r_row <= 7'd0;
                end else if (w_disp_line) begin
                    r_row <= r_row + 7'd1;
                end
            end
        end
    end

`ifdef PIXIE_DMA_OVERRUN_EN
    logic w_overrun_evt;
    logic r_overrun;

    assign w_overrun_evt = (r_state == S_REQ) && w_line_wrap;
    assign dma_overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_evt) begin
            r_overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixie_dma_sequencer.sv
// Self-checking bench for pixie_dma_sequencer: per-scenario tasks plus a write scoreboard.
module tb_pixie_dma_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_enable = 1'b0;
    logic [1:0] SC = 2'b00;
    logic       disp_on = 1'b0;
    logic       disp_off = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       DMAO, INT, EFx, mem_wr_en, frame_start;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
`ifdef PIXIE_DMA_OVERRUN_EN
    logic       dma_overrun;
`endif

    int total = 0;
    int bad = 0;
    int tickCount = 0;
    logic [17:0] expQ[$];
    logic prevWr = 1'b0;

    pixie_dma_sequencer dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .SC(SC),
        .disp_on(disp_on), .disp_off(disp_off), .data_in(data_in),
        .DMAO(DMAO), .INT(INT), .EFx(EFx), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr_en(mem_wr_en), .frame_start(frame_start)
`ifdef PIXIE_DMA_OVERRUN_EN
        , .dma_overrun(dma_overrun)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard: every write strobe must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            total++;
            if (prevWr) begin
                bad++;
                $display("[TB] FAIL wr_consecutive: mem_wr_en high two clks at addr %0d", mem_addr);
            end
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%h, none expected", mem_addr, mem_data);
            end else begin
                logic [17:0] e;
                e = expQ.pop_front();
                if ({mem_addr, mem_data} !== e)
                begin
                    bad++;
                    $display("[TB] FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_data, e[17:8], e[7:0]);
                end
            end
        end
        prevWr = mem_wr_en;
    end

    function automatic int lineNow();
        return (tickCount / 14) % 262;
    endfunction

    function automatic int cycleNow();
        return tickCount % 14;
    endfunction

    task automatic tick(input logic [1:0] sc, input logic [7:0] d);
        @(negedge clk);
        clk_enable = 1'b1;
        SC = sc;
        data_in = d;
        @(negedge clk);
        clk_enable = 1'b0;
        SC = 2'b00;
        tickCount++;
    endtask

    task automatic runTo(input int l, input int c, input logic [1:0] sc);
        for (int k = 0; k < 4000 && !(lineNow() == l && cycleNow() == c); k++) tick(sc, 8'hEE);
    endtask

    task automatic pulse(input logic on, input logic off);
        @(negedge clk);
        disp_on = on;
        disp_off = off;
        @(negedge clk);
        disp_on = 1'b0;
        disp_off = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({DMAO, INT, EFx, mem_wr_en, frame_start, mem_addr, mem_data} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero",
                     {DMAO, INT, EFx, mem_wr_en, frame_start, mem_addr, mem_data});
        end
        reset = 1'b0;
        tickCount = 0;
        for (int n = 0; n < 10; n++) tick(2'b00, 8'h00);
        total++;
        if ({DMAO, INT, EFx, mem_wr_en, frame_start} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL after_10_ticks: got %b, expected 00000",
                     {DMAO, INT, EFx, mem_wr_en, frame_start});
        end
    endtask

    task automatic test_flags(input logic en);
        int intTicks = 0;
        for (int k = 0; k < 2000 && !(lineNow() == 80 && cycleNow() == 0); k++) begin
            logic expEfx, expInt;
            tick(2'b00, 8'h00);
            expEfx = (lineNow() >= 76 && lineNow() <= 79);
            expInt = en && (lineNow() >= 78 && lineNow() <= 79);
            if (INT) intTicks++;
            total++;
            if (EFx !== expEfx || INT !== expInt) begin
                bad++;
                $display("[TB] FAIL flags line %0d cycle %0d: EFx=%b INT=%b, expected EFx=%b INT=%b",
                         lineNow(), cycleNow(), EFx, INT, expEfx, expInt);
            end
        end
        total++;
        if (intTicks != (en ? 28 : 0)) begin
            bad++;
            $display("[TB] FAIL int_ticks: got %0d, expected %0d", intTicks, en ? 28 : 0);
        end
    endtask

    task automatic dmaBurst(input int row, input logic [7:0] base);
        tick(2'b00, 8'h00);
        total++;
        if (DMAO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dmao_pre line %0d: got %b, expected 0", lineNow(), DMAO);
        end
        tick(2'b00, 8'h00);
        total++;
        if (DMAO !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dmao_rise line %0d: got %b, expected 1", lineNow(), DMAO);
        end
        for (int n = 0; n < 8; n++) begin
            logic [9:0] a;
            logic [7:0] d;
            a = 10'(row * 8 + n);
            d = base + 8'(n);
            expQ.push_back({a, d});
            tick(2'b10, d);
            total++;
            if (DMAO !== (n < 7)) begin
                bad++;
                $display("[TB] FAIL dmao_burst byte %0d: got %b, expected %b", n, DMAO, n < 7);
            end
        end
    endtask

    task automatic test_dma_first_line();
        dmaBurst(0, 8'hA0);
        runTo(81, 0, 2'b10);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL line80_pending: %0d writes missing, expected 0", expQ.size());
        end
    endtask

    task automatic test_disp_off();
        pulse(1'b1, 1'b0);
        tick(2'b00, 8'h00);
        tick(2'b00, 8'h00);
        for (int n = 0; n < 3; n++) begin
            expQ.push_back({10'(8 + n), 8'h50 + 8'(n)});
            tick(2'b10, 8'h50 + 8'(n));
        end
        pulse(1'b0, 1'b1);
        total++;
        if (DMAO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dmao_after_off: got %b, expected 0", DMAO);
        end
        runTo(82, 0, 2'b10);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL line81_pending: %0d writes missing, expected 0", expQ.size());
        end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        runTo(82, 3, 2'b00);
        total++;
        if (DMAO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL on_off_same_clk: DMAO=%b, expected 0", DMAO);
        end
    endtask

    task automatic test_starved();
        runTo(89, 5, 2'b00);
        pulse(1'b1, 1'b0);
`ifdef PIXIE_DMA_OVERRUN_EN
        total++;
        if (dma_overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_early: got %b, expected 0", dma_overrun);
        end
`endif
        runTo(90, 5, 2'b00);
        total++;
        if (DMAO !== 1'b1) begin
            bad++;
            $display("[TB] FAIL starved_req: DMAO=%b, expected 1", DMAO);
        end
        runTo(91, 0, 2'b00);
        total++;
        if (DMAO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL starved_idle: DMAO=%b, expected 0", DMAO);
        end
`ifdef PIXIE_DMA_OVERRUN_EN
        total++;
        if (dma_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_set: got %b, expected 1", dma_overrun);
        end
`endif
        dmaBurst(11, 8'h30);
        runTo(92, 0, 2'b00);
    endtask

    task automatic test_last_line();
        runTo(200, 0, 2'b00);
        for (int k = 0; k < 200 && !(lineNow() == 207 && cycleNow() == 0); k++) begin
            tick(2'b00, 8'h00);
            total++;
            if (EFx !== (lineNow() >= 204)) begin
                bad++;
                $display("[TB] FAIL efx_bottom line %0d: got %b, expected %b", lineNow(), EFx, lineNow() >= 204);
            end
        end
        dmaBurst(127, 8'hC0);
        runTo(208, 0, 2'b00);
        total++;
        if (EFx !== 1'b0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL line208: EFx=%b pending=%0d, expected 0 and 0", EFx, expQ.size());
        end
`ifdef PIXIE_DMA_OVERRUN_EN
        total++;
        if (dma_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_sticky: got %b, expected 1", dma_overrun);
        end
`endif
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_frame_start();
        int pulses = 0;
        for (int k = 0; k < 1000 && !(lineNow() == 0 && cycleNow() == 0); k++) begin
            tick(2'b00, 8'h00);
            if (frame_start) pulses++;
            total++;
            if (frame_start !== (lineNow() == 0 && cycleNow() == 0)) begin
                bad++;
                $display("[TB] FAIL frame_start line %0d cycle %0d: got %b", lineNow(), cycleNow(), frame_start);
            end
        end
        @(negedge clk);
        total++;
        if (frame_start !== 1'b0 || pulses != 1) begin
            bad++;
            $display("[TB] FAIL frame_start_width: level=%b pulses=%0d, expected 0 and 1", frame_start, pulses);
        end
    endtask

    task automatic test_reset_mid_dma();
        pulse(1'b1, 1'b0);
        tick(2'b00, 8'h00);
        tick(2'b00, 8'h00);
        for (int n = 0; n < 2; n++) begin
            expQ.push_back({10'(n), 8'h11 + 8'(n)});
            tick(2'b10, 8'h11 + 8'(n));
        end
        @(negedge clk);
        reset = 1'b1;
        clk_enable = 1'b1;
        SC = 2'b10;
        data_in = 8'hFF;
        @(negedge clk);
        total++;
        if ({DMAO, INT, EFx, mem_wr_en, frame_start, mem_addr, mem_data} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_dma: got %b, expected all zero",
                     {DMAO, INT, EFx, mem_wr_en, frame_start, mem_addr, mem_data});
        end
        reset = 1'b0;
        clk_enable = 1'b0;
        SC = 2'b00;
        tickCount = 0;
`ifdef PIXIE_DMA_OVERRUN_EN
        total++;
        if (dma_overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_reset: got %b, expected 0", dma_overrun);
        end
`endif
        for (int n = 0; n < 4; n++) tick(2'b10, 8'h77);
        total++;
        if (DMAO !== 1'b0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL post_reset: DMAO=%b pending=%0d, expected 0 and 0", DMAO, expQ.size());
        end
    endtask

    initial begin
        test_reset();
        pulse(1'b1, 1'b0);
        test_flags(1'b1);
        test_dma_first_line();
        test_disp_off();
        test_starved();
        test_last_line();
        test_frame_start();
        test_flags(1'b0);
        test_reset_mid_dma();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
